cache_line_ctrl: RTL and testbench
==================================

// Module: cache_line_ctrl
// PURPOSE
//  Controller for NUMLINES cache_line instances sharing one memory port.
//  Arbitrates the memory port among lines: round-robin grant, all other requesters paused.
//  When every line misses a pending request, picks a victim line and re-targets it.
//  Re-targeting is a flush (if dirty) plus a fill of the missed region.
//  Sits between the line array and the memory-port mux / hybrid cache top.
// PARAMETERS
//  NUMLINES     4   number of cache lines controlled
//  ADDRBITS     32  address width
//  MAXMISSBITS  8   width of each line's miss counter
//  LSBBITS      7   log2(words per line); region alignment = LSBBITS+2 address bits
// PORTS
//  clk           in   1                     system clock
//  reset_n       in   1                     asynchronous reset, active low
//  req_valid     in   1                     a dcache/icache request is pending
//  req_addr      in   ADDRBITS              address of the pending request
//  line_miss     in   NUMLINES              per-line cache_line_miss
//  line_dirty    in   NUMLINES              per-line cache_line_dirty
//  line_ready    in   NUMLINES              per-line cache_line_ready
//  line_misscnt  in   NUMLINES*MAXMISSBITS  per-line miss counters; line i at [i*MAXMISSBITS +: MAXMISSBITS]
//  line_memreq   in   NUMLINES              line i wants the memory port
//  line_flush    out  NUMLINES              one-cycle flush pulse per line
//  line_fill     out  NUMLINES              one-cycle fill pulse per line
//  line_pause    out  NUMLINES              pause to line i (memory port not granted)
//  mem_grant     out  NUMLINES              one-hot memory-port owner (mux select); 0 = none
//  new_region    out  ADDRBITS              region base for the fill; broadcast to all lines
//  ctrl_busy     out  1                     re-target sequence in progress
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - all outputs 0; FSM=IDLE; rr pointer=0; victim=0.
//   - Reset mid-sequence: pulses drop immediately; no partial flush/fill re-issued after release.
//  Arbiter (independent of FSM, registered):
//   - Owner keeps grant while its line_memreq=1.
//   - When the owner drops memreq, or there is no owner: next cycle grant goes to the
//     first requester searching from rr+1 upward, mod NUMLINES; rr <= new owner.
//   - line_pause[i] = line_memreq[i] & ~mem_grant[i], registered with the grant.
//   - No requests: mem_grant=0, pause=0.
//  FSM:
//   - IDLE -> SELECT when req_valid & (&line_miss).
//   - SELECT (1 cycle):
//     - victim = line with largest line_misscnt; ties go to the lowest index.
//     - new_region <= {req_addr[ADDRBITS-1:LSBBITS+2], {(LSBBITS+2){1'b0}}}.
//   - REFILL (1 cycle): line_fill[victim]=1; line_flush[victim]=line_dirty[victim].
//   - ACK: wait until line_ready[victim]=0 (line accepted the command).
//   - WAIT: wait until line_ready[victim]=1 -> IDLE.
//   - ctrl_busy=1 in every state except IDLE.
//   - Latency IDLE->pulse: 2 cycles after the triggering edge.
//   - req_valid / line_miss changes outside IDLE are ignored.
//   - Other lines keep serving hits while the victim refills.
//  Boundary cases:
//   - req_valid with any line hitting: no action.
//   - Single requester: granted on the first cycle the port is free.
//   - Arbitration during REFILL is unaffected by the FSM.
//   - line_flush/line_fill are never asserted for more than one line, or for more than one cycle.
// TESTING
//  1 Reset, idle: all outputs 0; mem_grant stays 0 with no line_memreq.
//  2 All miss, req_addr=12345678, misscnt={3,9,9,1}:
//    victim=1; new_region=12345600; fill[1] pulses 2 cycles later; busy until ready[1] returns.
//  3 Same as 2 with line_dirty[1]=1: flush[1] and fill[1] pulse in the same single cycle;
//    line_dirty[1]=0 -> flush stays 0.
//  4 line_memreq=4'b1111 held, each line drops its req after 3 cycles:
//    grant order 0001,0010,0100,1000; non-owners paused.
//  5 One line hits (line_miss=4'b1101) with req_valid=1: FSM stays IDLE, no pulses.
//  6 reset_n low during ACK: outputs clear asynchronously; FSM=IDLE; no further pulses after release.

Source files
------------

// File: rtl/cache_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_ctrl
// Purpose  : Round-robin memory-port arbiter and victim re-target sequencer
//            for an array of cache lines.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_ctrl #(
    parameter int NUMLINES    = 4,
    parameter int ADDRBITS    = 32,
    parameter int MAXMISSBITS = 8,
    parameter int LSBBITS     = 7
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    input  logic [ADDRBITS-1:0]             req_addr,
    input  logic [NUMLINES-1:0]             line_miss,
    input  logic [NUMLINES-1:0]             line_dirty,
    input  logic [NUMLINES-1:0]             line_ready,
    input  logic [NUMLINES*MAXMISSBITS-1:0] line_misscnt,
    input  logic [NUMLINES-1:0]             line_memreq,
    output logic [NUMLINES-1:0]             line_flush,
    output logic [NUMLINES-1:0]             line_fill,
    output logic [NUMLINES-1:0]             line_pause,
    output logic [NUMLINES-1:0]             mem_grant,
    output logic [ADDRBITS-1:0]             new_region,
    output logic                            ctrl_busy
);

    localparam int IDXW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
    localparam logic [ADDRBITS-1:0] C_REGION_MASK =
        {{(ADDRBITS-LSBBITS-2){1'b1}}, {(LSBBITS+2){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REFILL = 3'd2,
        ST_ACK    = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [IDXW-1:0]        r_rr;
    logic [IDXW-1:0]        r_victim;
    logic [NUMLINES-1:0]    w_next_grant;
    logic [IDXW-1:0]        w_next_rr;
    logic [IDXW-1:0]        w_max_idx;
    logic [MAXMISSBITS-1:0] w_max_cnt;
    logic                   w_found;
    int                     w_idx;

    // Owner keeps the port while requesting; otherwise search from rr+1 upward.
    always_comb begin
        w_next_grant = '0;
        w_next_rr    = r_rr;
        w_found      = 1'b0;
        w_idx        = 0;
        if ((mem_grant & line_memreq) != '0) begin
            w_next_grant = mem_grant;
        end else begin
            for (int k = 1; k <= NUMLINES; k++) begin
                w_idx = int'(r_rr) + k;
                if (w_idx >= NUMLINES) w_idx = w_idx - NUMLINES;
                if (!w_found && line_memreq[w_idx]) begin
                    w_found             = 1'b1;
                    w_next_grant[w_idx] = 1'b1;
                    w_next_rr           = w_idx[IDXW-1:0];
                end
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_max_idx = '0;
        w_max_cnt = line_misscnt[0 +: MAXMISSBITS];
        for (int i = 1; i < NUMLINES; i++) begin
            if (line_misscnt[i*MAXMISSBITS +: MAXMISSBITS] > w_max_cnt) begin
                w_max_cnt = line_misscnt[i*MAXMISSBITS +: MAXMISSBITS];
                w_max_idx = i[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_grant  <= '0;
            line_pause <= '0;
            r_rr       <= '0;
        end else begin
            mem_grant  <= w_next_grant;
            line_pause <= line_memreq & ~w_next_grant;
            r_rr       <= w_next_rr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_victim   <= '0;
            new_region <= '0;
            line_flush <= '0;
            line_fill  <= '0;
            ctrl_busy  <= 1'b0;
        end else begin
            line_flush <= '0;
            line_fill  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && (&line_miss)) begin
                        r_state   <= ST_SELECT;
                        ctrl_busy <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    r_victim   <= w_max_idx;
                    new_region <= req_addr & C_REGION_MASK;
                    r_state    <= ST_REFILL;
                end
                ST_REFILL: begin
                    line_fill[r_victim]  <= 1'b1;
                    line_flush[r_victim] <= line_dirty[r_victim];
                    r_state              <= ST_ACK;
                end
                ST_ACK: begin
                    if (!line_ready[r_victim]) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (line_ready[r_victim]) begin
                        r_state   <= ST_IDLE;
                        ctrl_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    ctrl_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_ctrl
// Purpose  : Directed self-checking bench for cache_line_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  line_miss, line_dirty, line_ready, line_memreq;
    logic [31:0] line_misscnt;
    logic [3:0]  line_flush, line_fill, line_pause, mem_grant;
    logic [31:0] new_region;
    logic        ctrl_busy;

    int total = 0;
    int bad   = 0;

    cache_line_ctrl #(
        .NUMLINES(4), .ADDRBITS(32), .MAXMISSBITS(8), .LSBBITS(7)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .line_miss(line_miss), .line_dirty(line_dirty), .line_ready(line_ready),
        .line_misscnt(line_misscnt), .line_memreq(line_memreq),
        .line_flush(line_flush), .line_fill(line_fill), .line_pause(line_pause),
        .mem_grant(mem_grant), .new_region(new_region), .ctrl_busy(ctrl_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one all-miss re-target sequence; the victim drops ready to accept.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] cnt,
                              input logic [3:0] dirty, input int vic,
                              input logic [31:0] exp_region, input logic [3:0] exp_flush);
        logic [3:0] vic_oh;
        vic_oh       = 4'b0001 << vic;
        req_addr     = addr;
        line_misscnt = cnt;
        line_dirty   = dirty;
        line_miss    = 4'b1111;
        req_valid    = 1'b1;
        tick();
        chk("busy_select", {31'd0, ctrl_busy}, 32'd1);
        chk("fill_early1", {28'd0, line_fill}, 32'd0);
        tick();
        chk("region", new_region, exp_region);
        chk("fill_early2", {28'd0, line_fill}, 32'd0);
        tick();
        chk("fill_pulse", {28'd0, line_fill}, {28'd0, vic_oh});
        chk("flush_pulse", {28'd0, line_flush}, {28'd0, exp_flush});
        req_valid = 1'b0;
        line_miss = 4'b0000;
        tick();
        chk("fill_single", {28'd0, line_fill}, 32'd0);
        chk("flush_single", {28'd0, line_flush}, 32'd0);
        chk("busy_ack", {31'd0, ctrl_busy}, 32'd1);
        line_ready[vic] = 1'b0;
        tick();
        chk("busy_wait", {31'd0, ctrl_busy}, 32'd1);
        line_ready[vic] = 1'b1;
        tick();
        chk("busy_done", {31'd0, ctrl_busy}, 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        line_miss    = '0;
        line_dirty   = '0;
        line_ready   = 4'b1111;
        line_misscnt = '0;
        line_memreq  = '0;
        tick();
        tick();
        chk("rst_grant", {28'd0, mem_grant}, 32'd0);
        chk("rst_fill", {28'd0, line_fill}, 32'd0);
        chk("rst_flush", {28'd0, line_flush}, 32'd0);
        chk("rst_region", new_region, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_grant", {28'd0, mem_grant}, 32'd0);
        chk("idle_pause", {28'd0, line_pause}, 32'd0);
        chk("idle_busy", {31'd0, ctrl_busy}, 32'd0);

        // Line i count at [i*8 +: 8]: lines 0..3 = 3,9,9,1.
        run_refill(32'h1234_5678, {8'd1, 8'd9, 8'd9, 8'd3}, 4'b1101, 1, 32'h1234_5600, 4'b0000);
        run_refill(32'h1234_5678, {8'd1, 8'd9, 8'd9, 8'd3}, 4'b0010, 1, 32'h1234_5600, 4'b0010);
        run_refill(32'hABCD_EFFF, {8'd7, 8'd2, 8'd2, 8'd2}, 4'b1000, 3, 32'hABCD_EE00, 4'b1000);

        // One line hits: no action.
        req_valid = 1'b1;
        line_miss = 4'b1101;
        for (int i = 0; i < 4; i++) tick();
        chk("hit_busy", {31'd0, ctrl_busy}, 32'd0);
        chk("hit_fill", {28'd0, line_fill}, 32'd0);
        req_valid = 1'b0;
        line_miss = 4'b0000;

        // Single requester leaves rr at 3, so the full sweep starts at line 0.
        line_memreq = 4'b1000;
        tick();
        chk("single_grant", {28'd0, mem_grant}, 32'h8);
        chk("single_pause", {28'd0, line_pause}, 32'd0);
        line_memreq = 4'b0000;
        tick();
        chk("drop_grant", {28'd0, mem_grant}, 32'd0);
        line_memreq = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", {28'd0, mem_grant}, 32'd1 << k);
            chk("rr_pause", {28'd0, line_pause}, {28'd0, line_memreq & ~(4'b0001 << k)});
            tick();
            tick();
            chk("rr_hold", {28'd0, mem_grant}, 32'd1 << k);
            line_memreq[k] = 1'b0;
        end
        tick();
        chk("rr_empty", {28'd0, mem_grant}, 32'd0);

        // Reset asserted while the fill pulse is out in ACK.
        line_memreq  = 4'b0001;
        req_addr     = 32'h0000_1234;
        line_misscnt = {8'd0, 8'd0, 8'd5, 8'd0};
        line_dirty   = 4'b1111;
        line_miss    = 4'b1111;
        req_valid    = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_fill", {28'd0, line_fill}, 32'h2);
        chk("pre_rst_grant", {28'd0, mem_grant}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_fill", {28'd0, line_fill}, 32'd0);
        chk("arst_flush", {28'd0, line_flush}, 32'd0);
        chk("arst_busy", {31'd0, ctrl_busy}, 32'd0);
        chk("arst_grant", {28'd0, mem_grant}, 32'd0);
        chk("arst_region", new_region, 32'd0);
        req_valid   = 1'b0;
        line_miss   = 4'b0000;
        line_memreq = 4'b0000;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_fill", {28'd0, line_fill | line_flush}, 32'd0);
        end
        chk("post_rst_busy", {31'd0, ctrl_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
